core_dcache: RTL and testbench



---
 rtl/core_dcache_pkg.sv | 30 +++
 rtl/core_dcache_array.sv | 67 ++++++
 rtl/core_dcache.sv | 268 ++++++++++++++++++++++++++
 tb/tb_core_dcache.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_dcache_pkg.sv
// ============================================================================
// Module   : core_dcache_pkg
// Brief    : Shared constants, address fields and FSM encoding for core_dcache
// Revision : 1.0
// ============================================================================
`default_nettype none

package core_dcache_pkg;

    localparam int HEAD_WR    = 3;
    localparam int HEAD_V     = 2;
    localparam int HEAD_NLL   = 1;
    localparam int HEAD_NSC   = 0;

    localparam int LINE_WORDS = 4;
    localparam int OFF_LO     = 2;
    localparam int OFF_HI     = 3;
    localparam int IDX_LO     = 4;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_REFILL_REQ  = 3'd1,
        S_REFILL_WAIT = 3'd2,
        S_WRITE_REQ   = 3'd3,
        S_RESPOND     = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/core_dcache_array.sv
// ============================================================================
// Module   : core_dcache_array
// Brief    : Tag/valid/data storage with word write, line set/clear, snoop clear
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_dcache_array
    import core_dcache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 32 - 4 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [1:0]       rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_word,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [1:0]       wr_off,
    input  logic [31:0]      wr_word,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_idx,
    input  logic [TAG_W-1:0] inv_tag
);

    logic [31:0]      r_data_mem [LINES*LINE_WORDS];
    logic [TAG_W-1:0] r_tag_mem  [LINES];
    logic [LINES-1:0] r_valid;

    assign rd_valid = r_valid[rd_idx];
    assign rd_tag   = r_tag_mem[rd_idx];
    assign rd_word  = r_data_mem[{rd_idx, rd_off}];

    always_ff @(posedge clk) begin
        if (wr_en)
            r_data_mem[{wr_idx, wr_off}] <= wr_word;
        if (set_en)
            r_tag_mem[set_idx] <= set_tag;
    end

    // The snoop compares against the stored tag; a line under refill was already cleared
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
        end else begin
            if (set_en)
                r_valid[set_idx] <= 1'b1;
            if (clr_en)
                r_valid[clr_idx] <= 1'b0;
            if (inv_en && r_valid[inv_idx] && (r_tag_mem[inv_idx] == inv_tag))
                r_valid[inv_idx] <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_dcache.sv
// ============================================================================
// Module   : core_dcache
// Brief    : Direct-mapped write-through L1 data cache with LL/SC link and snoop
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_dcache
    import core_dcache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 32 - 4 - IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v_mem,
    input  logic [3:0]  mem_head,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic        v_data,
    output logic [31:0] data,
    output logic        busy,
    output logic        v_req,
    output logic [3:0]  req_head,
    output logic [31:0] req_addr,
    output logic [31:0] req_data,
    input  logic        req_ack,
    input  logic        v_rsp,
    input  logic [31:0] rsp_data,
    input  logic        inv_v,
    input  logic [31:0] inv_addr
);

    state_t r_state, w_state_nxt;

    logic        r_v_data;
    logic [31:0] r_data;
    logic [3:0]  r_req_head;
    logic [31:0] r_req_addr;
    logic [31:0] r_req_data;
    logic [27:0] r_line;
    logic [1:0]  r_off;
    logic [1:0]  r_beat;
    logic        r_is_ll;
    logic        r_is_sc;
    logic        r_fill_inv;
    logic [31:0] r_fill_word;
    logic        r_link_valid;
    logic [27:0] r_link_addr;

    logic             w_rd_valid;
    logic [TAG_W-1:0] w_rd_tag;
    logic [31:0]      w_rd_word;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [1:0]       w_off;
    logic             w_accept, w_is_wr, w_is_ll, w_is_sc;
    logic             w_hit, w_inv_same, w_inv_fill, w_link_match;
    logic             w_arr_wr_en, w_set_en, w_clr_en;
    logic [IDX_W-1:0] w_arr_wr_idx;
    logic [1:0]       w_arr_wr_off;
    logic [31:0]      w_arr_wr_word;
    logic             w_link_set, w_link_clr;
    logic [27:0]      w_link_new;
    logic             w_unused;

    assign w_unused     = ^{mem_addr[1:0], inv_addr[3:0]};
    assign w_idx        = mem_addr[IDX_LO +: IDX_W];
    assign w_tag        = mem_addr[31:IDX_LO+IDX_W];
    assign w_off        = mem_addr[OFF_HI:OFF_LO];
    assign busy         = (r_state != S_IDLE);
    assign w_accept     = v_mem && mem_head[HEAD_V] && !busy;
    assign w_is_wr      = mem_head[HEAD_WR];
    assign w_is_ll      = !w_is_wr && !mem_head[HEAD_NLL];
    assign w_is_sc      = w_is_wr && !mem_head[HEAD_NSC];
    assign w_link_match = r_link_valid && (r_link_addr == mem_addr[31:4]);
    // A snoop to the requested line in the same cycle forces the miss path
    assign w_inv_same   = inv_v && (inv_addr[31:4] == mem_addr[31:4]);
    assign w_hit        = w_rd_valid && (w_rd_tag == w_tag) && !w_inv_same;
    assign w_inv_fill   = inv_v && (inv_addr[31:4] == r_line);

    assign v_data   = r_v_data;
    assign data     = r_data;
    assign v_req    = (r_state == S_REFILL_REQ) || (r_state == S_WRITE_REQ);
    assign req_head = r_req_head;
    assign req_addr = r_req_addr;
    assign req_data = r_req_data;

    core_dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (w_idx),
        .rd_off   (w_off),
        .rd_valid (w_rd_valid),
        .rd_tag   (w_rd_tag),
        .rd_word  (w_rd_word),
        .wr_en    (w_arr_wr_en),
        .wr_idx   (w_arr_wr_idx),
        .wr_off   (w_arr_wr_off),
        .wr_word  (w_arr_wr_word),
        .set_en   (w_set_en),
        .set_idx  (r_line[IDX_W-1:0]),
        .set_tag  (r_line[27:IDX_W]),
        .clr_en   (w_clr_en),
        .clr_idx  (w_idx),
        .inv_en   (inv_v),
        .inv_idx  (inv_addr[IDX_LO +: IDX_W]),
        .inv_tag  (inv_addr[31:IDX_LO+IDX_W])
    );

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_arr_wr_en   = 1'b0;
        w_arr_wr_idx  = w_idx;
        w_arr_wr_off  = w_off;
        w_arr_wr_word = mem_data;
        w_set_en      = 1'b0;
        w_clr_en      = 1'b0;
        w_link_set    = 1'b0;
        w_link_clr    = 1'b0;
        w_link_new    = mem_addr[31:4];
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_is_wr) begin
                        w_link_set = w_is_ll && w_hit;
                        if (!w_hit) begin
                            // Refill overwrites the words, so the old line dies now
                            w_state_nxt = S_REFILL_REQ;
                            w_clr_en    = 1'b1;
                        end
                    end else begin
                        w_link_clr = w_is_sc || w_link_match;
                        if (!w_is_sc || w_link_match) begin
                            w_state_nxt = S_WRITE_REQ;
                            w_arr_wr_en = w_hit;
                        end
                    end
                end
            end
            S_REFILL_REQ: begin
                if (req_ack)
                    w_state_nxt = S_REFILL_WAIT;
            end
            S_REFILL_WAIT: begin
                w_arr_wr_idx  = r_line[IDX_W-1:0];
                w_arr_wr_off  = r_beat;
                w_arr_wr_word = rsp_data;
                w_link_new    = r_line;
                if (v_rsp) begin
                    w_arr_wr_en = 1'b1;
                    if (r_beat == 2'd3) begin
                        w_state_nxt = S_RESPOND;
                        w_set_en    = !r_fill_inv && !w_inv_fill;
                        w_link_set  = r_is_ll;
                    end
                end
            end
            S_WRITE_REQ: begin
                if (req_ack)
                    w_state_nxt = S_RESPOND;
            end
            S_RESPOND: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v_data     <= 1'b0;
            r_data       <= '0;
            r_req_head   <= '0;
            r_req_addr   <= '0;
            r_req_data   <= '0;
            r_line       <= '0;
            r_off        <= '0;
            r_beat       <= '0;
            r_is_ll      <= 1'b0;
            r_is_sc      <= 1'b0;
            r_fill_inv   <= 1'b0;
            r_fill_word  <= '0;
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
        end else begin
            r_v_data <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_line     <= mem_addr[31:4];
                        r_off      <= w_off;
                        r_is_ll    <= w_is_ll;
                        r_is_sc    <= w_is_sc;
                        r_beat     <= '0;
                        r_fill_inv <= 1'b0;
                        if (!w_is_wr) begin
                            if (w_hit) begin
                                r_v_data <= 1'b1;
                                r_data   <= w_rd_word;
                            end else begin
                                r_req_head <= {1'b0, mem_head[2:0]};
                                r_req_addr <= {mem_addr[31:4], 4'b0000};
                                r_req_data <= '0;
                            end
                        end else if (!w_is_sc || w_link_match) begin
                            r_req_head <= mem_head;
                            r_req_addr <= mem_addr;
                            r_req_data <= mem_data;
                        end else begin
                            r_v_data <= 1'b1;
                            r_data   <= '0;
                        end
                    end
                end
                S_REFILL_REQ: begin
                    if (w_inv_fill)
                        r_fill_inv <= 1'b1;
                end
                S_REFILL_WAIT: begin
                    if (w_inv_fill)
                        r_fill_inv <= 1'b1;
                    if (v_rsp) begin
                        r_beat <= r_beat + 2'd1;
                        if (r_beat == r_off)
                            r_fill_word <= rsp_data;
                        if (r_beat == 2'd3) begin
                            r_v_data <= 1'b1;
                            r_data   <= (r_off == 2'd3) ? rsp_data : r_fill_word;
                        end
                    end
                end
                S_WRITE_REQ: begin
                    if (req_ack) begin
                        r_v_data <= 1'b1;
                        r_data   <= {31'b0, r_is_sc};
                    end
                end
                default: begin
                end
            endcase

            if (w_link_set) begin
                r_link_valid <= !(inv_v && (inv_addr[31:4] == w_link_new));
                r_link_addr  <= w_link_new;
            end else if (w_link_clr || (inv_v && (inv_addr[31:4] == r_link_addr))) begin
                r_link_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_core_dcache.sv
// ============================================================================
// Module   : tb_core_dcache
// Brief    : Directed self-checking bench for core_dcache
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_core_dcache;

    localparam logic [3:0] H_LD = 4'b0111;
    localparam logic [3:0] H_LL = 4'b0101;
    localparam logic [3:0] H_ST = 4'b1111;
    localparam logic [3:0] H_SC = 4'b1110;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v_mem = 1'b0;
    logic [3:0]  mem_head = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic        v_data;
    logic [31:0] data;
    logic        busy;
    logic        v_req;
    logic [3:0]  req_head;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_ack = 1'b0;
    logic        v_rsp = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        inv_v = 1'b0;
    logic [31:0] inv_addr = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    core_dcache dut (
        .clk      (clk),
        .rst      (rst),
        .v_mem    (v_mem),
        .mem_head (mem_head),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .v_data   (v_data),
        .data     (data),
        .busy     (busy),
        .v_req    (v_req),
        .req_head (req_head),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_ack  (req_ack),
        .v_rsp    (v_rsp),
        .rsp_data (rsp_data),
        .inv_v    (inv_v),
        .inv_addr (inv_addr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] h, input logic [31:0] a, input logic [31:0] d);
        v_mem = 1'b1; mem_head = h; mem_addr = a; mem_data = d;
        tick();
        v_mem = 1'b0;
    endtask

    task automatic ack_now;
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
    endtask

    task automatic beats(input logic [31:0] b);
        for (int i = 0; i < 4; i++) begin
            v_rsp = 1'b1; rsp_data = b + 32'(i);
            tick();
        end
        v_rsp = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick(); tick();
        total++; if ({v_data, busy, v_req} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {v_data, busy, v_req}); end
        total++; if (data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", data); end
        total++; if ({req_head, req_addr, req_data} !== 68'h0) begin bad++; $display("FAIL reset_req got=%h want=0", {req_head, req_addr, req_data}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_miss_hit;
        req(H_LD, 32'h0000_1004, 32'h0);
        total++; if ({busy, v_req} !== 2'b11) begin bad++; $display("FAIL miss_busy_vreq got=%b want=11", {busy, v_req}); end
        total++; if (req_addr !== 32'h0000_1000) begin bad++; $display("FAIL miss_req_addr got=%h want=00001000", req_addr); end
        total++; if (req_head !== 4'b0111) begin bad++; $display("FAIL miss_req_head got=%b want=0111", req_head); end
        v_rsp = 1'b1; rsp_data = 32'hDEAD;
        tick();
        v_rsp = 1'b0;
        total++; if ({v_req, req_addr} !== {1'b1, 32'h0000_1000}) begin bad++; $display("FAIL miss_hold got=%h want=100001000", {v_req, req_addr}); end
        ack_now();
        total++; if ({busy, v_req, v_data} !== 3'b100) begin bad++; $display("FAIL miss_wait got=%b want=100", {busy, v_req, v_data}); end
        beats(32'hA0);
        total++; if ({v_data, data} !== {1'b1, 32'hA1}) begin bad++; $display("FAIL miss_resp got=%h want=1000000a1", {v_data, data}); end
        tick();
        total++; if ({v_data, busy} !== 2'b00) begin bad++; $display("FAIL miss_idle got=%b want=00", {v_data, busy}); end
        req(H_LD, 32'h0000_100C, 32'h0);
        total++; if ({v_data, data} !== {1'b1, 32'hA3}) begin bad++; $display("FAIL hit_data got=%h want=1000000a3", {v_data, data}); end
        total++; if ({v_req, busy} !== 2'b00) begin bad++; $display("FAIL hit_noreq got=%b want=00", {v_req, busy}); end
    endtask

    task automatic test_write_hit;
        req(H_ST, 32'h0000_1008, 32'h55);
        total++; if ({v_req, req_head, req_addr, req_data} !== {1'b1, 4'b1111, 32'h0000_1008, 32'h55}) begin
            bad++; $display("FAIL wr_req got=%h want=1f0000100800000055", {v_req, req_head, req_addr, req_data}); end
        total++; if (v_data !== 1'b0) begin bad++; $display("FAIL wr_early_vdata got=%b want=0", v_data); end
        ack_now();
        total++; if ({v_data, data} !== {1'b1, 32'h0}) begin bad++; $display("FAIL wr_resp got=%h want=100000000", {v_data, data}); end
        tick();
        req(H_LD, 32'h0000_1008, 32'h0);
        total++; if ({v_data, data, v_req} !== {1'b1, 32'h55, 1'b0}) begin bad++; $display("FAIL wr_readback got=%h want=2000000aa", {v_data, data, v_req}); end
    endtask

    task automatic test_llsc;
        req(H_LL, 32'h0000_2000, 32'h0);
        total++; if ({v_req, req_head} !== {1'b1, 4'b0101}) begin bad++; $display("FAIL ll_req got=%h want=15", {v_req, req_head}); end
        ack_now();
        beats(32'hB0);
        total++; if ({v_data, data} !== {1'b1, 32'hB0}) begin bad++; $display("FAIL ll_resp got=%h want=1000000b0", {v_data, data}); end
        tick();
        req(H_SC, 32'h0000_2000, 32'h7);
        total++; if ({v_req, req_head, req_addr, req_data} !== {1'b1, 4'b1110, 32'h0000_2000, 32'h7}) begin
            bad++; $display("FAIL sc_req got=%h want=1e0000200000000007", {v_req, req_head, req_addr, req_data}); end
        ack_now();
        total++; if ({v_data, data} !== {1'b1, 32'h1}) begin bad++; $display("FAIL sc_ok got=%h want=100000001", {v_data, data}); end
        tick();
        req(H_SC, 32'h0000_2000, 32'h8);
        total++; if ({v_data, data, v_req, busy} !== {1'b1, 32'h0, 2'b00}) begin bad++; $display("FAIL sc_again got=%h want=400000000", {v_data, data, v_req, busy}); end
    endtask

    task automatic test_sc_snoop;
        req(H_LL, 32'h0000_2000, 32'h0);
        total++; if ({v_data, data, v_req} !== {1'b1, 32'h7, 1'b0}) begin bad++; $display("FAIL ll_hit got=%h want=20000000e", {v_data, data, v_req}); end
        inv_v = 1'b1; inv_addr = 32'h0000_2000;
        tick();
        inv_v = 1'b0;
        req(H_SC, 32'h0000_2000, 32'h9);
        total++; if ({v_data, data, v_req} !== {1'b1, 32'h0, 1'b0}) begin bad++; $display("FAIL sc_snooped got=%h want=200000000", {v_data, data, v_req}); end
        req(H_LD, 32'h0000_2000, 32'h0);
        total++; if ({v_req, v_data} !== 2'b10) begin bad++; $display("FAIL snoop_miss got=%b want=10", {v_req, v_data}); end
        ack_now();
        beats(32'hF0);
        total++; if ({v_data, data} !== {1'b1, 32'hF0}) begin bad++; $display("FAIL snoop_refill got=%h want=1000000f0", {v_data, data}); end
        tick();
        // Snoop and hit to the same line in one cycle: must take the miss path
        inv_v = 1'b1; inv_addr = 32'h0000_2008;
        req(H_LD, 32'h0000_2004, 32'h0);
        inv_v = 1'b0;
        total++; if ({v_req, v_data} !== 2'b10) begin bad++; $display("FAIL inv_vs_hit got=%b want=10", {v_req, v_data}); end
        ack_now();
        beats(32'hC0);
        total++; if ({v_data, data} !== {1'b1, 32'hC1}) begin bad++; $display("FAIL inv_vs_hit_data got=%h want=1000000c1", {v_data, data}); end
        tick();
    endtask

    task automatic test_conflict;
        req(H_LD, 32'h0000_1000, 32'h0);
        total++; if (v_req !== 1'b1) begin bad++; $display("FAIL conf_a_miss got=%b want=1", v_req); end
        ack_now(); beats(32'hD0); tick();
        req(H_LD, 32'h0000_1400, 32'h0);
        total++; if ({v_req, req_addr} !== {1'b1, 32'h0000_1400}) begin bad++; $display("FAIL conf_b_miss got=%h want=100001400", {v_req, req_addr}); end
        ack_now(); beats(32'hE0);
        total++; if ({v_data, data} !== {1'b1, 32'hE0}) begin bad++; $display("FAIL conf_b_data got=%h want=1000000e0", {v_data, data}); end
        tick();
        req(H_LD, 32'h0000_1000, 32'h0);
        total++; if (v_req !== 1'b1) begin bad++; $display("FAIL conf_a_again got=%b want=1", v_req); end
        ack_now();
        // Snoop the line while its beats arrive: data returned, line left invalid
        inv_v = 1'b1; inv_addr = 32'h0000_1000;
        v_rsp = 1'b1; rsp_data = 32'h10;
        tick();
        inv_v = 1'b0;
        for (int i = 1; i < 4; i++) begin
            rsp_data = 32'h10 + 32'(i);
            tick();
        end
        v_rsp = 1'b0;
        total++; if ({v_data, data} !== {1'b1, 32'h10}) begin bad++; $display("FAIL inv_fill_data got=%h want=100000010", {v_data, data}); end
        tick();
        req(H_LD, 32'h0000_1000, 32'h0);
        total++; if ({v_req, v_data} !== 2'b10) begin bad++; $display("FAIL inv_fill_invalid got=%b want=10", {v_req, v_data}); end
        ack_now(); beats(32'h20); tick();
    endtask

    task automatic test_reset_mid_refill;
        req(H_LD, 32'h0000_3000, 32'h0);
        total++; if (v_req !== 1'b1) begin bad++; $display("FAIL rmr_miss got=%b want=1", v_req); end
        ack_now();
        v_rsp = 1'b1; rsp_data = 32'h30; tick();
        rsp_data = 32'h31; tick();
        rsp_data = 32'h32; rst = 1'b0; tick();
        v_rsp = 1'b0; rst = 1'b1;
        total++; if ({v_data, busy, v_req} !== 3'b000) begin bad++; $display("FAIL rmr_dropped got=%b want=000", {v_data, busy, v_req}); end
        tick();
        total++; if (v_data !== 1'b0) begin bad++; $display("FAIL rmr_no_vdata got=%b want=0", v_data); end
        req(H_LD, 32'h0000_3000, 32'h0);
        total++; if ({v_req, busy, v_data} !== 3'b110) begin bad++; $display("FAIL rmr_remiss got=%b want=110", {v_req, busy, v_data}); end
        rst = 1'b0; tick(); rst = 1'b1; tick();
    endtask

    initial begin
        test_reset();
        test_miss_hit();
        test_write_hit();
        test_llsc();
        test_sc_snoop();
        test_conflict();
        test_reset_mid_refill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
